// File: rtl/dsp19x2_fir_pkg.sv
// Shared constants and types for the DSP19X2 4-tap dual-lane FIR sequencer.
package dsp19x2_fir_pkg;

    localparam int TAPS = 4;
    localparam int A_W  = 10;
    localparam int B_W  = 9;
    localparam int Z_W  = 19;

    localparam logic [2:0] FB_CLEAR = 3'b001;
    localparam logic [2:0] FB_ACC   = 3'b000;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/dsp19x2_fir_result_fifo.sv
// Result FIFO holding {Z1, Z2} pairs between the DSP pipeline and the output stream.
module dsp19x2_fir_result_fifo
    import dsp19x2_fir_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 2 * Z_W,
    localparam int CW   = $clog2(DEPTH + 1),
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  head,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_pop;

    assign do_pop = pop && (count != '0);
    assign head   = mem[rd_ptr];

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Storage, wrapping pointers and occupancy count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= bump(wr_ptr);
            end
            if (do_pop) rd_ptr <= bump(rd_ptr);
            case ({push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Credit accounting upstream must make a push into a full FIFO impossible.
    ast_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && (count == CW'(DEPTH))));

endmodule

// File: rtl/dsp19x2_fir_sequencer.sv
// Drives a DSP19X2 in multiply-accumulate mode as a 4-tap dual-lane FIR,
// one tap per clock, and buffers results behind a credit-checked FIFO.
module dsp19x2_fir_sequencer
    import dsp19x2_fir_pkg::*;
#(
    parameter int         DSP_LATENCY  = 3,
    parameter int         RESULT_DEPTH = 4,
    parameter logic       UNSIGNED_A_P = 1'b0,
    parameter logic       UNSIGNED_B_P = 1'b0,
    parameter logic [4:0] SHIFT_P      = 5'd0,
    parameter logic       ROUND_P      = 1'b0,
    parameter logic       SATURATE_P   = 1'b0
) (
    input  logic           CLK,
    input  logic           RESET_N,
    input  logic           IN_VALID,
    output logic           IN_READY,
    input  logic [B_W-1:0] IN_B1,
    input  logic [B_W-1:0] IN_B2,
    input  logic           COEF_WE,
    input  logic [1:0]     COEF_ADDR,
    input  logic [A_W-1:0] COEF_DATA1,
    input  logic [A_W-1:0] COEF_DATA2,
    output logic [A_W-1:0] DSP_A1,
    output logic [A_W-1:0] DSP_A2,
    output logic [B_W-1:0] DSP_B1,
    output logic [B_W-1:0] DSP_B2,
    output logic [2:0]     DSP_FEEDBACK,
    output logic           DSP_LOAD_ACC,
    output logic [4:0]     DSP_ACC_FIR,
    output logic           DSP_SUBTRACT,
    output logic           DSP_UNSIGNED_A,
    output logic           DSP_UNSIGNED_B,
    output logic [4:0]     DSP_SHIFT_RIGHT,
    output logic           DSP_ROUND,
    output logic           DSP_SATURATE,
    input  logic [Z_W-1:0] DSP_Z1,
    input  logic [Z_W-1:0] DSP_Z2,
    output logic           OUT_VALID,
    input  logic           OUT_READY,
    output logic [Z_W-1:0] OUT_Z1,
    output logic [Z_W-1:0] OUT_Z2
);

    // state | meaning
    // IDLE  | no tap issued this cycle, DSP_LOAD_ACC low
    // RUN   | tap 'tap' of the current sample is on the DSP inputs

    localparam int CW = $clog2(RESULT_DEPTH + 1);

    state_t               state, state_nxt;
    logic [1:0]           tap, tap_nxt;
    logic                 accept;
    logic                 live;
    logic [A_W-1:0]       coef1 [TAPS];
    logic [A_W-1:0]       coef2 [TAPS];
    logic [B_W-1:0]       d1 [TAPS];
    logic [B_W-1:0]       d2 [TAPS];
    logic [CW-1:0]        inflight;
    logic [CW-1:0]        fifo_count;
    logic [DSP_LATENCY-1:0] marker;
    logic                 marker_in;
    logic                 push;
    logic                 pop;
    logic [2*Z_W-1:0]     head;

    assign DSP_ACC_FIR     = 5'd0;
    assign DSP_SUBTRACT    = 1'b0;
    assign DSP_UNSIGNED_A  = UNSIGNED_A_P;
    assign DSP_UNSIGNED_B  = UNSIGNED_B_P;
    assign DSP_SHIFT_RIGHT = SHIFT_P;
    assign DSP_ROUND       = ROUND_P;
    assign DSP_SATURATE    = SATURATE_P;

    // A freshly started sequencer can take a sample only at a sample boundary
    // and only if a FIFO slot is reserved for every result still in flight.
    assign IN_READY = live && ((state == IDLE) || (tap == 2'(TAPS - 1))) &&
                      (({1'b0, inflight} + {1'b0, fifo_count}) < (CW + 1)'(RESULT_DEPTH));
    assign accept    = IN_VALID && IN_READY;
    assign marker_in = (state == RUN) && (tap == 2'(TAPS - 1));
    assign push      = marker[DSP_LATENCY-1];
    assign OUT_VALID = (fifo_count != '0);
    assign pop       = OUT_VALID && OUT_READY;
    assign OUT_Z1    = head[2*Z_W-1:Z_W];
    assign OUT_Z2    = head[Z_W-1:0];

    // State and tap registers; 'live' keeps IN_READY low through reset.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= IDLE;
            tap   <= '0;
            live  <= 1'b0;
        end else begin
            state <= state_nxt;
            tap   <= tap_nxt;
            live  <= 1'b1;
        end
    end

    // Next state: one tap per cycle, back-to-back samples restart at tap 0.
    always_comb begin
        state_nxt = state;
        tap_nxt   = tap;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = RUN;
                    tap_nxt   = '0;
                end
            end
            RUN: begin
                if (tap != 2'(TAPS - 1)) begin
                    tap_nxt = tap + 1'b1;
                end else if (accept) begin
                    tap_nxt = '0;
                end else begin
                    state_nxt = IDLE;
                    tap_nxt   = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                tap_nxt   = '0;
            end
        endcase
    end

    // Registered tap drive; tap 0 takes the sample straight from the input
    // since the delay line shifts on the same edge.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            DSP_A1       <= '0;
            DSP_A2       <= '0;
            DSP_B1       <= '0;
            DSP_B2       <= '0;
            DSP_FEEDBACK <= FB_CLEAR;
            DSP_LOAD_ACC <= 1'b0;
        end else if (state_nxt == RUN) begin
            DSP_A1       <= coef1[tap_nxt];
            DSP_A2       <= coef2[tap_nxt];
            DSP_B1       <= (tap_nxt == '0) ? IN_B1 : d1[tap_nxt];
            DSP_B2       <= (tap_nxt == '0) ? IN_B2 : d2[tap_nxt];
            DSP_FEEDBACK <= (tap_nxt == '0) ? FB_CLEAR : FB_ACC;
            DSP_LOAD_ACC <= 1'b1;
        end else begin
            DSP_FEEDBACK <= FB_CLEAR;
            DSP_LOAD_ACC <= 1'b0;
        end
    end

    // Coefficient bank; writes take effect for the next tap issued.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < TAPS; i++) begin
                coef1[i] <= '0;
                coef2[i] <= '0;
            end
        end else if (COEF_WE) begin
            coef1[COEF_ADDR] <= COEF_DATA1;
            coef2[COEF_ADDR] <= COEF_DATA2;
        end
    end

    // Per-lane sample delay lines, d[0] newest.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < TAPS; i++) begin
                d1[i] <= '0;
                d2[i] <= '0;
            end
        end else if (accept) begin
            d1[0] <= IN_B1;
            d2[0] <= IN_B2;
            for (int k = 1; k < TAPS; k++) begin
                d1[k] <= d1[k-1];
                d2[k] <= d2[k-1];
            end
        end
    end

    // Marker pipe tracks each sample's last tap through the DSP latency;
    // inflight counts accepted samples not yet pushed into the FIFO.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            marker   <= '0;
            inflight <= '0;
        end else begin
            marker <= {marker[DSP_LATENCY-2:0], marker_in};
            case ({accept, push})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: ;
            endcase
        end
    end

    dsp19x2_fir_result_fifo #(
        .DEPTH (RESULT_DEPTH),
        .W     (2 * Z_W)
    ) u_result_fifo (
        .clk       (CLK),
        .rst_n     (RESET_N),
        .push      (push),
        .push_data ({DSP_Z1, DSP_Z2}),
        .pop       (pop),
        .head      (head),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_dsp19x2_fir_sequencer.sv
// Directed bench for the FIR sequencer with a small behavioural DSP19X2 MAC.
module tb_dsp19x2_fir_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [8:0]  in_b1 = '0, in_b2 = '0;
    logic        coef_we = 1'b0;
    logic [1:0]  coef_addr = '0;
    logic [9:0]  coef_data1 = '0, coef_data2 = '0;
    logic [9:0]  dsp_a1, dsp_a2;
    logic [8:0]  dsp_b1, dsp_b2;
    logic [2:0]  dsp_feedback;
    logic        dsp_load_acc;
    logic [4:0]  dsp_acc_fir;
    logic        dsp_subtract, dsp_unsigned_a, dsp_unsigned_b;
    logic [4:0]  dsp_shift_right;
    logic        dsp_round, dsp_saturate;
    logic [18:0] dsp_z1, dsp_z2;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [18:0] out_z1, out_z2;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cyc = -1;
    int first_ov = -1;
    logic gap_load = 1'b0;
    logic [17:0] in_q[$];
    logic [37:0] res_q[$];

    dsp19x2_fir_sequencer dut (
        .CLK(clk), .RESET_N(rst_n),
        .IN_VALID(in_valid), .IN_READY(in_ready), .IN_B1(in_b1), .IN_B2(in_b2),
        .COEF_WE(coef_we), .COEF_ADDR(coef_addr), .COEF_DATA1(coef_data1), .COEF_DATA2(coef_data2),
        .DSP_A1(dsp_a1), .DSP_A2(dsp_a2), .DSP_B1(dsp_b1), .DSP_B2(dsp_b2),
        .DSP_FEEDBACK(dsp_feedback), .DSP_LOAD_ACC(dsp_load_acc), .DSP_ACC_FIR(dsp_acc_fir),
        .DSP_SUBTRACT(dsp_subtract), .DSP_UNSIGNED_A(dsp_unsigned_a), .DSP_UNSIGNED_B(dsp_unsigned_b),
        .DSP_SHIFT_RIGHT(dsp_shift_right), .DSP_ROUND(dsp_round), .DSP_SATURATE(dsp_saturate),
        .DSP_Z1(dsp_z1), .DSP_Z2(dsp_z2),
        .OUT_VALID(out_valid), .OUT_READY(out_ready), .OUT_Z1(out_z1), .OUT_Z2(out_z2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural DSP19X2: input register, signed MAC accumulator, output register.
    logic [9:0]  ra1, ra2;
    logic [8:0]  rb1, rb2;
    logic [2:0]  rfb;
    logic        rld;
    logic [18:0] acc1, acc2;

    function automatic logic [18:0] mac(input logic [9:0] a, input logic [8:0] b);
        logic signed [18:0] sa, sb;
        sa = {{9{a[9]}}, a};
        sb = {{10{b[8]}}, b};
        return 19'(sa * sb);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ra1 <= '0; ra2 <= '0; rb1 <= '0; rb2 <= '0; rfb <= 3'b001; rld <= 1'b0;
            acc1 <= '0; acc2 <= '0; dsp_z1 <= '0; dsp_z2 <= '0;
        end else begin
            ra1 <= dsp_a1; ra2 <= dsp_a2; rb1 <= dsp_b1; rb2 <= dsp_b2;
            rfb <= dsp_feedback; rld <= dsp_load_acc;
            if (rld) begin
                acc1 <= ((rfb == 3'b001) ? 19'd0 : acc1) + mac(ra1, rb1);
                acc2 <= ((rfb == 3'b001) ? 19'd0 : acc2) + mac(ra2, rb2);
            end
            dsp_z1 <= acc1;
            dsp_z2 <= acc2;
        end
    end

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) res_q.push_back({out_z1, out_z2});
        if (out_valid && first_ov < 0) first_ov = cyc;
    end

    task automatic chk_val(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic wr_bank(input logic [3:0][9:0] c1, input logic [3:0][9:0] c2);
        for (int i = 0; i < 4; i++) begin
            coef_we = 1'b1; coef_addr = 2'(i); coef_data1 = c1[i]; coef_data2 = c2[i];
            @(posedge clk); #1;
        end
        coef_we = 1'b0;
    endtask

    task automatic drive(input int gap, input int budget, output int left);
        int  n = 0;
        logic got;
        while (in_q.size() > 0 && n < budget) begin
            in_valid = 1'b1; in_b1 = in_q[0][17:9]; in_b2 = in_q[0][8:0];
            @(negedge clk); got = in_ready;
            @(posedge clk); #1; n++;
            if (got) begin
                if (acc_cyc < 0) acc_cyc = cyc;
                void'(in_q.pop_front());
                if (gap > 0) begin
                    in_valid = 1'b0;
                    for (int g = 1; g <= gap; g++) begin
                        @(posedge clk); #1; n++;
                        if (g == 6) gap_load = gap_load | dsp_load_acc;
                    end
                end
            end
        end
        in_valid = 1'b0;
        left = in_q.size();
    endtask

    task automatic wait_res(input string tag, input int want, input int budget);
        int n = 0;
        while (res_q.size() < want && n < budget) begin @(posedge clk); #1; n++; end
        chk_val(tag, res_q.size(), want);
    endtask

    task automatic chk_res(input string tag, input int idx, input logic [18:0] e1, input logic [18:0] e2);
        logic [37:0] r;
        r = (idx < res_q.size()) ? res_q[idx] : '1;
        chk_val($sformatf("%s_z1_%0d", tag, idx), r[37:19], e1);
        chk_val($sformatf("%s_z2_%0d", tag, idx), r[18:0], e2);
    endtask

    int left;
    logic got;
    int n;

    initial begin
        // Reset values
        repeat (2) @(negedge clk);
        chk_val("rst_in_ready", in_ready, 0);
        chk_val("rst_out_valid", out_valid, 0);
        chk_val("rst_feedback", dsp_feedback, 3'b001);
        chk_val("rst_load_acc", dsp_load_acc, 0);
        chk_val("rst_out_z1", out_z1, 0);
        chk_val("rst_dsp_a1", dsp_a1, 0);
        @(posedge clk); #1; rst_n = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        chk_val("idle_in_ready", in_ready, 1);
        chk_val("const_shift", dsp_shift_right, 0);
        chk_val("const_subtract", {dsp_subtract, dsp_acc_fir}, 0);

        // Impulse response, back-to-back, plus accept-to-valid latency
        wr_bank({10'd4, 10'd3, 10'd2, 10'd1}, {10'd1, 10'd2, 10'd3, 10'd4});
        out_ready = 1'b1; res_q.delete(); first_ov = -1; acc_cyc = -1;
        in_q = '{{9'd1, 9'd1}, 18'd0, 18'd0, 18'd0, 18'd0};
        drive(0, 100, left);
        chk_val("b2b_left", left, 0);
        wait_res("b2b_count", 5, 60);
        for (int i = 0; i < 5; i++)
            chk_res("b2b", i, (i < 4) ? 19'(i + 1) : 19'd0, (i < 4) ? 19'(4 - i) : 19'd0);
        chk_val("latency", 64'(first_ov - acc_cyc), 7);

        // Same stream with idle gaps
        res_q.delete(); gap_load = 1'b0;
        in_q = '{{9'd1, 9'd1}, 18'd0, 18'd0, 18'd0, 18'd0};
        drive(8, 200, left);
        chk_val("gap_left", left, 0);
        chk_val("gap_idle_load", gap_load, 0);
        wait_res("gap_count", 5, 60);
        for (int i = 0; i < 5; i++)
            chk_res("gap", i, (i < 4) ? 19'(i + 1) : 19'd0, (i < 4) ? 19'(4 - i) : 19'd0);

        // Signed arithmetic
        wr_bank({10'd0, 10'd0, 10'd0, 10'h3FF}, {10'd0, 10'd0, 10'd0, 10'd0});
        res_q.delete();
        in_q = '{{9'h1FF, 9'd0}, {9'h0FF, 9'd0}};
        drive(0, 50, left);
        wait_res("sgn_count", 2, 40);
        chk_res("sgn", 0, 19'd1, 19'd0);
        chk_res("sgn", 1, 19'h7FF01, 19'd0);

        // Backpressure: only RESULT_DEPTH samples get in while the output is stalled
        wr_bank({10'd0, 10'd0, 10'd0, 10'd1}, {10'd0, 10'd0, 10'd1, 10'd0});
        out_ready = 1'b0; res_q.delete();
        in_q.delete();
        for (int i = 1; i <= 8; i++) in_q.push_back({9'(i), 9'(i)});
        drive(0, 40, left);
        chk_val("bp_left", left, 4);
        @(negedge clk);
        chk_val("bp_in_ready", in_ready, 0);
        chk_val("bp_out_valid", out_valid, 1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        drive(0, 100, left);
        chk_val("bp_left2", left, 0);
        wait_res("bp_count", 8, 60);
        for (int i = 0; i < 8; i++) chk_res("bp", i, 19'(i + 1), 19'(i));

        // Reset during tap 2 with two results queued
        wr_bank({10'd4, 10'd3, 10'd2, 10'd1}, {10'd1, 10'd2, 10'd3, 10'd4});
        out_ready = 1'b0; res_q.delete();
        in_q = '{{9'd1, 9'd1}, 18'd0, 18'd0, 18'd0};
        drive(0, 40, left);
        repeat (2) begin @(posedge clk); #1; end
        chk_val("mid_fb", dsp_feedback, 3'b000);
        chk_val("mid_out_valid", out_valid, 1);
        rst_n = 1'b0; #1;
        chk_val("mid_rst_out_valid", out_valid, 0);
        chk_val("mid_rst_load", dsp_load_acc, 0);
        chk_val("mid_rst_in_ready", in_ready, 0);
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        wr_bank({10'd4, 10'd3, 10'd2, 10'd1}, {10'd1, 10'd2, 10'd3, 10'd4});
        out_ready = 1'b1; res_q.delete();
        in_q = '{{9'd1, 9'd1}, 18'd0, 18'd0, 18'd0};
        drive(0, 40, left);
        wait_res("post_rst_count", 4, 40);
        for (int i = 0; i < 4; i++) chk_res("post_rst", i, 19'(i + 1), 19'(4 - i));
        repeat (12) begin @(posedge clk); #1; end
        chk_val("post_rst_no_extra", res_q.size(), 4);

        // Coefficient write at E+1 to tap 3 of a sample in progress
        res_q.delete();
        in_q = '{{9'd2, 9'd2}, 18'd0, 18'd0};
        drive(0, 40, left);
        in_valid = 1'b1; in_b1 = 9'd7; in_b2 = 9'd7; got = 1'b0; n = 0;
        while (!got && n < 20) begin
            @(negedge clk); got = in_ready;
            @(posedge clk); #1; n++;
        end
        in_valid = 1'b0;
        chk_val("cw_accept", got, 1);
        coef_we = 1'b1; coef_addr = 2'd3; coef_data1 = 10'd10; coef_data2 = 10'd6;
        @(posedge clk); #1;
        coef_we = 1'b0;
        wait_res("cw_count", 4, 40);
        chk_res("cw", 0, 19'd2, 19'd8);
        chk_res("cw", 1, 19'd4, 19'd6);
        chk_res("cw", 2, 19'd6, 19'd4);
        chk_res("cw", 3, 19'd27, 19'd40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
